udma_tx_arbiter: RTL

- Round-robin arbiter that shares one L2 read port among N_CH uDMA TX linear channels.
- Each channel presents a TX req/gnt read request (address, datasize). The block forwards the winner to the memory port and records the channel ID in an in-order outstanding FIFO.
- Read responses are routed back to the owning channel as a valid pulse.
- Sits between the per-channel TX address generators and the uDMA core's L2 TX port.

---
 rtl/udma_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/udma_tx_arbiter.sv
// Round-robin arbiter sharing one L2 read port among N_CH uDMA TX channels.
// Granted channel IDs are queued in order so each read response returns to its owner.
module udma_tx_arbiter #(
  parameter int N_CH    = 4,
  parameter int AW      = 19,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_CH-1:0]               ch_req_i,
  input  logic [N_CH*AW-1:0]            ch_addr_i,
  input  logic [N_CH*2-1:0]             ch_datasize_i,
  output logic [N_CH-1:0]               ch_gnt_o,
  output logic [N_CH-1:0]               ch_valid_o,
  output logic [DW-1:0]                 ch_data_o,
  output logic                          mem_req_o,
  output logic [AW-1:0]                 mem_addr_o,
  output logic [1:0]                    mem_datasize_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic [DW-1:0]                 mem_rdata_i,
  output logic [$clog2(MAX_OUT):0]      outstanding_o,
  output logic                          err_o
);

  localparam int IW = $clog2(N_CH);
  localparam int PW = $clog2(MAX_OUT);
  localparam int OW = PW + 1;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_id_q, lock_id_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          err_q, err_d;
  logic [IW-1:0] fifo_q [MAX_OUT];

  logic [IW-1:0] win;
  logic          found;
  logic          full;
  logic          mem_req;
  logic          accept;
  logic          pop;

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win   = rr_ptr_q;
    found = 1'b0;
    if (lock_q) begin
      win = lock_id_q;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!found && ch_req_i[(int'(rr_ptr_q) + i) % N_CH]) begin
          win   = IW'((int'(rr_ptr_q) + i) % N_CH);
          found = 1'b1;
        end
      end
    end
  end

  // Outputs are forced low while reset is held, even though inputs may be active.
  assign full    = (occ_q == OW'(MAX_OUT));
  assign mem_req = ~rst_i & (|ch_req_i) & ~full;
  assign accept  = mem_req & mem_gnt_i;
  assign pop     = ~rst_i & mem_rvalid_i & (occ_q != '0);

  assign mem_req_o      = mem_req;
  assign mem_addr_o     = mem_req ? ch_addr_i[int'(win)*AW +: AW] : '0;
  assign mem_datasize_o = mem_req ? ch_datasize_i[int'(win)*2 +: 2] : 2'b00;
  assign ch_gnt_o       = accept ? (N_CH'(1) << win) : '0;
  assign ch_valid_o     = pop ? (N_CH'(1) << fifo_q[rd_ptr_q]) : '0;
  assign ch_data_o      = pop ? mem_rdata_i : '0;
  assign outstanding_o  = occ_q;
  assign err_o          = err_q;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    err_d     = err_q | (mem_rvalid_i & (occ_q == '0));

    if (accept) begin
      rr_ptr_d = (int'(win) == N_CH - 1) ? '0 : win + 1'b1;
      lock_d   = 1'b0;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (mem_req) begin
      // Freeze the winner until the memory accepts so its request fields never change.
      lock_d    = 1'b1;
      lock_id_d = win;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({accept, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
    end
  end

  // NOTE: FIFO storage is not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= win;
    end
  end

endmodule
